// File: rtl/ins_loader_pkg.sv
// Shared state encoding and word-width constant for the instruction loader.
package ins_loader_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_WRITE,
    ST_CKSUM,
    ST_DONE,
    ST_ERR
  } state_t;

  // States in which the byte stream is being consumed.
  function automatic logic accepts_bytes(input state_t s);
    return (s == ST_LEN) || (s == ST_DATA) || (s == ST_CKSUM);
  endfunction

endpackage

// File: rtl/ins_loader_byte_packer.sv
// Collects four bytes little-endian into a 32-bit word; word_valid flags the 4th byte.
module ins_loader_byte_packer
  import ins_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              byte_en,
  input  logic [7:0]        byte_data,
  output logic              word_valid,
  output logic [WORD_W-1:0] word_next,
  output logic [WORD_W-1:0] word
);

  logic [1:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0] shift_q, shift_d;

  // New bytes enter at the top so the first byte ends up in bits [7:0].
  assign word_next  = {byte_data, shift_q[WORD_W-1:8]};
  assign word_valid = byte_en && !clear && (cnt_q == 2'd3);
  assign word       = shift_q;

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (clear) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (byte_en) begin
      cnt_d   = cnt_q + 2'd1;
      shift_d = word_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/ins_loader.sv
// Boot-time program loader: byte stream -> instruction memory, holding the core meanwhile.
// Optional trailing checksum stage enabled by defining INS_LOADER_CKSUM_EN.
module ins_loader
  import ins_loader_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  localparam logic [WORD_W-1:0] CAPACITY = 32'd1 << ADDR_W;
  localparam logic [ADDR_W:0]   IDX_ONE  = {{ADDR_W{1'b0}}, 1'b1};

`ifdef INS_LOADER_CKSUM_EN
  localparam state_t END_ST = ST_CKSUM;
`else
  localparam state_t END_ST = ST_DONE;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   idx_inc;
  logic              in_ready_q, in_ready_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              byte_en;
  logic              start_ok;
  logic              word_valid;
  logic [WORD_W-1:0] word_next;
  logic [WORD_W-1:0] word;

  assign byte_en  = in_valid && in_ready_q;
  assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));
  assign idx_inc  = idx_q + IDX_ONE;

  ins_loader_byte_packer u_byte_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_ok),
    .byte_en    (byte_en),
    .byte_data  (in_data),
    .word_valid (word_valid),
    .word_next  (word_next),
    .word       (word)
  );

`ifdef INS_LOADER_CKSUM_EN
  logic [WORD_W-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (start_ok) begin
      csum_d = '0;
    end else if (state_q == ST_WRITE) begin
      csum_d = csum_q + word;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_ok) begin
          state_d = ST_LEN;
          idx_d   = '0;
          len_d   = '0;
        end
      end
      ST_LEN: begin
        if (word_valid) begin
          // N == 2^ADDR_W is legal, hence the ADDR_W+1 bit length register.
          if (word_next > CAPACITY) begin
            state_d = ST_ERR;
          end else begin
            len_d   = word_next[ADDR_W:0];
            state_d = (word_next == '0) ? END_ST : ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (word_valid) begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        idx_d   = idx_inc;
        state_d = (idx_inc == len_q) ? END_ST : ST_DATA;
      end
`ifdef INS_LOADER_CKSUM_EN
      ST_CKSUM: begin
        if (word_valid) begin
          state_d = (word_next == csum_q) ? ST_DONE : ST_ERR;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_comb begin
    in_ready_d = accepts_bytes(state_d);
    cpu_hold_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d     = (state_d == ST_DONE) && (state_q != ST_DONE);
    err_d      = (state_d == ST_ERR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      len_q      <= '0;
      in_ready_q <= 1'b0;
      cpu_hold_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      in_ready_q <= in_ready_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = (state_q == ST_WRITE);
  assign imem_addr  = BASE_ADDR + (32'(idx_q) << 2);
  assign imem_wdata = word;
  assign cpu_hold   = cpu_hold_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
